// File: rtl/vector_field_packer_pkg.sv
// rtl/vector_field_packer_pkg.sv - width helpers and alignment function for the field packer
package vec_pack_pkg;

  // Upper bound on any staging vector handed to left_align.
  localparam int MAX_W = 512;

  function automatic int off_w(input int in_w);
    return (in_w > 1) ? $clog2(in_w) : 1;
  endfunction

  function automatic int len_w(input int in_w);
    return $clog2(in_w) + 1;
  endfunction

  function automatic int bits_w(input int out_w);
    return $clog2(out_w) + 1;
  endfunction

  // Moves the low cnt bits of stg to the top of an out_w-bit word; the caller truncates to out_w.
  function automatic logic [MAX_W-1:0] left_align(input logic [MAX_W-1:0] stg,
                                                  input int unsigned cnt,
                                                  input int unsigned out_w);
    return stg << (out_w - cnt);
  endfunction

endpackage

// File: rtl/vector_field_packer_if.sv
// rtl/vector_field_packer_if.sv - input beat / output word handshake bundle
interface vector_field_packer_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
);
  import vec_pack_pkg::*;

  localparam int OFF_W  = off_w(IN_W);
  localparam int LEN_W  = len_w(IN_W);
  localparam int BITS_W = bits_w(OUT_W);

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic [OFF_W-1:0]  in_off;
  logic [LEN_W-1:0]  in_len;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [BITS_W-1:0] out_bits;
  logic              err;

  modport master (
    output in_valid, in_data, in_off, in_len, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_bits, err
  );

  modport slave (
    input  in_valid, in_data, in_off, in_len, in_last, out_ready,
    output in_ready, out_valid, out_data, out_bits, err
  );

endinterface

// File: rtl/vector_field_extract.sv
// rtl/vector_field_extract.sv - combinational runtime bit-field selector with overrange flag
module vector_field_extract
  import vec_pack_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic [IN_W-1:0]         i_data,
  input  logic [off_w(IN_W)-1:0]  i_off,
  input  logic [len_w(IN_W)-1:0]  i_len,
  output logic [IN_W-1:0]         o_field,
  output logic                    o_overrange
);
  localparam int LEN_W = len_w(IN_W);

  logic [IN_W-1:0]  w_shifted;
  logic [IN_W-1:0]  w_mask;
  logic [LEN_W:0]   w_end;

  always_comb begin
    w_shifted   = i_data >> i_off;
    // A shift by IN_W or more clears the vector, so i_len == IN_W yields an all-ones mask.
    w_mask      = ~({IN_W{1'b1}} << i_len);
    o_field     = w_shifted & w_mask;
    w_end       = (LEN_W + 1)'(i_off) + (LEN_W + 1)'(i_len);
    o_overrange = w_end > (LEN_W + 1)'(IN_W);
  end

endmodule

// File: rtl/vector_field_packer.sv
// rtl/vector_field_packer.sv - concatenates runtime bit-fields MSB-first into fixed-width output words
module vector_field_packer
  import vec_pack_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  vector_field_packer_if.slave bus
);
  localparam int BITS_W = bits_w(OUT_W);
  localparam int SW     = OUT_W + IN_W;

  logic               r_rst_q;
  logic               r_flush;
  logic               r_err;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_stg;
  logic [OUT_W-1:0]   r_out_data;
  logic [BITS_W-1:0]  r_cnt;
  logic [BITS_W-1:0]  r_out_bits;

  logic [IN_W-1:0]    w_field;
  logic               w_overrange;
  logic               w_out_free;
  logic               w_in_ready;
  logic               w_accept;
  logic [BITS_W-1:0]  w_n;
  logic [SW-1:0]      w_stg_next;
  logic [OUT_W-1:0]   w_full_word;
  logic [OUT_W-1:0]   w_last_word;
  logic [OUT_W-1:0]   w_flush_word;

  vector_field_extract #(.IN_W(IN_W)) u_extract (
    .i_data      (bus.in_data),
    .i_off       (bus.in_off),
    .i_len       (bus.in_len),
    .o_field     (w_field),
    .o_overrange (w_overrange)
  );

  always_comb begin
    w_out_free   = !r_out_valid || bus.out_ready;
    w_in_ready   = !rst && !r_rst_q && !r_flush && w_out_free;
    w_accept     = bus.in_valid && w_in_ready;
    w_n          = r_cnt + BITS_W'(bus.in_len);
    w_stg_next   = (SW'(r_stg) << bus.in_len) | SW'(w_field);
    // n never exceeds 2*OUT_W-1, so the top OUT_W of the n live bits is the full word.
    w_full_word  = OUT_W'(w_stg_next >> (w_n - BITS_W'(OUT_W)));
    w_last_word  = OUT_W'(left_align(MAX_W'(w_stg_next), 32'(w_n), OUT_W));
    w_flush_word = OUT_W'(left_align(MAX_W'(r_stg), 32'(r_cnt), OUT_W));
  end

  always_ff @(posedge clk) begin
    r_rst_q <= rst;
    if (rst) begin
      r_flush     <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_stg       <= '0;
      r_out_data  <= '0;
      r_cnt       <= '0;
      r_out_bits  <= '0;
    end else begin
      if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        r_stg <= w_stg_next[OUT_W-1:0];
        if (w_overrange) begin
          r_err <= 1'b1;
        end
        if (w_n >= BITS_W'(OUT_W)) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_full_word;
          r_out_bits  <= BITS_W'(OUT_W);
          r_cnt       <= w_n - BITS_W'(OUT_W);
          if (bus.in_last && (w_n != BITS_W'(OUT_W))) begin
            r_flush <= 1'b1;
          end
        end else if (bus.in_last && (w_n != '0)) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_last_word;
          r_out_bits  <= w_n;
          r_cnt       <= '0;
        end else begin
          r_cnt <= w_n;
        end
      end else if (r_flush && w_out_free) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_flush_word;
        r_out_bits  <= r_cnt;
        r_cnt       <= '0;
        r_flush     <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_bits  = r_out_bits;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_vector_field_packer.sv
// tb/tb_vector_field_packer.sv - directed self-checking bench for vector_field_packer
module tb_vector_field_packer;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  vector_field_packer_if #(.IN_W(8), .OUT_W(8)) bus ();

  vector_field_packer #(.IN_W(8), .OUT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // Offers one beat, waiting (bounded) for in_ready, then returns #1 after the accepting edge.
  task automatic beat(input logic [7:0] d, input logic [2:0] o, input logic [3:0] l,
                      input logic last);
    int k;
    k = 0;
    bus.in_data  = d;
    bus.in_off   = o;
    bus.in_len   = l;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL beat_accept in_ready=%b after 20 cycles, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    idle();
    vectors++;
    if ({bus.out_valid, bus.out_data, bus.out_bits, bus.err, bus.in_ready} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got v=%b d=%h b=%0d e=%b r=%b, required all 0",
               bus.out_valid, bus.out_data, bus.out_bits, bus.err, bus.in_ready);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_after_ready got %b, required 0", bus.in_ready);
    end
    idle();
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready got %b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_nibble_concat();
    beat(8'h0E, 3'd0, 4'd4, 1'b0);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL nibble_first_valid got %b, required 0", bus.out_valid);
    end
    beat(8'h7F, 3'd0, 4'd4, 1'b0);
    vectors++;
    if ({bus.out_valid, bus.out_data, bus.out_bits} !== {1'b1, 8'hEF, 4'd8}) begin
      miscompares++;
      $display("FAIL nibble_word got v=%b d=%h b=%0d, required v=1 d=ef b=8",
               bus.out_valid, bus.out_data, bus.out_bits);
    end
    idle();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL nibble_drain got %b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_repeated_slice();
    for (int i = 0; i < 3; i++) begin
      beat(8'hF5, 3'd2, 4'd2, 1'b0);
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL slice_partial_%0d got valid %b, required 0", i, bus.out_valid);
      end
    end
    beat(8'hF5, 3'd2, 4'd2, 1'b0);
    vectors++;
    if ({bus.out_valid, bus.out_data, bus.out_bits} !== {1'b1, 8'h55, 4'd8}) begin
      miscompares++;
      $display("FAIL slice_word got v=%b d=%h b=%0d, required v=1 d=55 b=8",
               bus.out_valid, bus.out_data, bus.out_bits);
    end
    idle();
  endtask

  task automatic test_straddle_flush();
    beat(8'h3F, 3'd0, 4'd6, 1'b0);
    beat(8'h00, 3'd0, 4'd6, 1'b0);
    vectors++;
    if ({bus.out_valid, bus.out_data, bus.out_bits} !== {1'b1, 8'hFC, 4'd8}) begin
      miscompares++;
      $display("FAIL straddle_word got v=%b d=%h b=%0d, required v=1 d=fc b=8",
               bus.out_valid, bus.out_data, bus.out_bits);
    end
    beat(8'hFF, 3'd0, 4'd0, 1'b1);
    vectors++;
    if ({bus.out_valid, bus.out_data, bus.out_bits} !== {1'b1, 8'h00, 4'd4}) begin
      miscompares++;
      $display("FAIL straddle_flush got v=%b d=%h b=%0d, required v=1 d=00 b=4",
               bus.out_valid, bus.out_data, bus.out_bits);
    end
    idle();
  endtask

  task automatic test_overflow_last();
    beat(8'h3F, 3'd0, 4'd6, 1'b0);
    beat(8'h0A, 3'd0, 4'd4, 1'b1);
    vectors++;
    if ({bus.out_valid, bus.out_data, bus.out_bits, bus.in_ready} !== {1'b1, 8'hFE, 4'd8, 1'b0}) begin
      miscompares++;
      $display("FAIL overflow_word got v=%b d=%h b=%0d rdy=%b, required v=1 d=fe b=8 rdy=0",
               bus.out_valid, bus.out_data, bus.out_bits, bus.in_ready);
    end
    idle();
    vectors++;
    if ({bus.out_valid, bus.out_data, bus.out_bits, bus.in_ready} !== {1'b1, 8'h80, 4'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL overflow_flush got v=%b d=%h b=%0d rdy=%b, required v=1 d=80 b=2 rdy=1",
               bus.out_valid, bus.out_data, bus.out_bits, bus.in_ready);
    end
    idle();
  endtask

  task automatic test_full_last();
    beat(8'hA5, 3'd0, 4'd8, 1'b1);
    vectors++;
    if ({bus.out_valid, bus.out_data, bus.out_bits, bus.in_ready} !== {1'b1, 8'hA5, 4'd8, 1'b1}) begin
      miscompares++;
      $display("FAIL full_last_word got v=%b d=%h b=%0d rdy=%b, required v=1 d=a5 b=8 rdy=1",
               bus.out_valid, bus.out_data, bus.out_bits, bus.in_ready);
    end
    idle();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_last_extra got valid %b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    beat(8'hAB, 3'd0, 4'd8, 1'b0);
    bus.in_data  = 8'hCD;
    bus.in_off   = 3'd0;
    bus.in_len   = 4'd8;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({bus.out_valid, bus.out_data, bus.out_bits, bus.in_ready} !== {1'b1, 8'hAB, 4'd8, 1'b0}) begin
        miscompares++;
        $display("FAIL hold_%0d got v=%b d=%h b=%0d rdy=%b, required v=1 d=ab b=8 rdy=0",
                 i, bus.out_valid, bus.out_data, bus.out_bits, bus.in_ready);
      end
      idle();
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_ready got %b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.out_data, bus.out_bits} !== {1'b1, 8'hCD, 4'd8}) begin
      miscompares++;
      $display("FAIL release_word got v=%b d=%h b=%0d, required v=1 d=cd b=8",
               bus.out_valid, bus.out_data, bus.out_bits);
    end
    idle();
  endtask

  task automatic test_overrange_reset();
    beat(8'hFF, 3'd6, 4'd4, 1'b0);
    vectors++;
    if ({bus.err, bus.out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL overrange_err got err=%b v=%b, required err=1 v=0", bus.err, bus.out_valid);
    end
    beat(8'h0A, 3'd0, 4'd4, 1'b0);
    vectors++;
    if ({bus.out_valid, bus.out_data, bus.err} !== {1'b1, 8'h3A, 1'b1}) begin
      miscompares++;
      $display("FAIL overrange_word got v=%b d=%h err=%b, required v=1 d=3a err=1",
               bus.out_valid, bus.out_data, bus.err);
    end
    beat(8'h07, 3'd0, 4'd3, 1'b0);
    rst = 1'b1;
    idle();
    vectors++;
    if ({bus.err, bus.out_valid, bus.in_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL midreset got err=%b v=%b rdy=%b, required all 0",
               bus.err, bus.out_valid, bus.in_ready);
    end
    rst = 1'b0;
    beat(8'h05, 3'd0, 4'd8, 1'b0);
    vectors++;
    if ({bus.out_valid, bus.out_data, bus.out_bits, bus.err} !== {1'b1, 8'h05, 4'd8, 1'b0}) begin
      miscompares++;
      $display("FAIL stale_bits got v=%b d=%h b=%0d err=%b, required v=1 d=05 b=8 err=0",
               bus.out_valid, bus.out_data, bus.out_bits, bus.err);
    end
    idle();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_off    = '0;
    bus.in_len    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_nibble_concat();
    test_repeated_slice();
    test_straddle_flush();
    test_overflow_last();
    test_full_last();
    test_backpressure();
    test_overrange_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vector_field_packer.md
Name: vector_field_packer

Overview:
- Parametrised successor to the team's fixed-width slice/concatenate vector logic.
- Each accepted input beat selects a runtime bit-field (offset and length) from an IN_W-bit word.
- Selected fields are concatenated MSB-first into OUT_W-bit output words; the first field lands in the most significant bits.
- Fields may straddle output words. An explicit last flag flushes a partial word. Valid/ready handshakes on both sides.

Parameters:
- IN_W, 8, input word width. Legal range: 1 ≤ IN_W ≤ OUT_W.
- OUT_W, 8, output word width. Legal range: ≥ 2.

Ports:
- clk  in  1  single clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat offered.
- in_ready  out  1  block can accept a beat.
- in_data  in  IN_W  source word.
- in_off  in  clog2(IN_W) (min 1)  LSB index of the field.
- in_len  in  clog2(IN_W)+1  field length, 0..IN_W. A length of 0 appends nothing.
- in_last  in  1  flush after this beat.
- out_valid  out  1  output word valid.
- out_ready  in  1  sink accepts the word.
- out_data  out  OUT_W  packed word; valid bits are left-aligned.
- out_bits  out  clog2(OUT_W)+1  count of valid MSBs in out_data; equals OUT_W unless the word is a flush.
- err  out  1  sticky: a beat was accepted with in_off+in_len > IN_W.

Behaviour:
- Reset: synchronous. While rst=1 and on the cycle after:
  - out_valid=0, out_data=0, out_bits=0, err=0, in_ready=0.
  - Staging count cnt=0; flush_pending=0.
  - Reset mid-operation discards staged bits and any pending flush.
- in_ready = !rst_q && !flush_pending && (!out_valid || out_ready).
- Accept = in_valid && in_ready.
  - Field f = (in_data >> in_off) masked to in_len bits. Bits above IN_W-1 read as 0.
  - If in_off+in_len > IN_W, set err; it holds until reset.
- Staging: register stg holds cnt bits right-aligned, with cnt < OUT_W between beats.
  - On accept: stg' = (stg << in_len) | f and n = cnt + in_len. Since n < 2·OUT_W, at most one full word is produced per beat.
- Emit on the accept cycle; outputs are registered, so latency is 1 cycle from accept to out_valid:
  - n ≥ OUT_W: out_data = stg'[n-1 -: OUT_W], out_bits=OUT_W, cnt = n-OUT_W.
    - If in_last and cnt>0, set flush_pending.
  - n < OUT_W with in_last and n>0: out_data = stg' left-aligned with zero-padded LSBs, out_bits=n, cnt=0.
  - n < OUT_W without in_last: no output, cnt=n.
  - in_last with n==0 or n==OUT_W: no extra word.
- flush_pending: when the output register frees (!out_valid || out_ready), load the remaining cnt bits left-aligned with zero pad. Then out_bits=cnt, cnt=0, flush_pending=0.
- Output hold: while out_valid && !out_ready, out_data and out_bits are stable and in_ready=0.
- Throughput: one beat per cycle when out_ready is held high. The only bubble is a flush_pending cycle.
- Simultaneous events: an output drain and a new accept in the same cycle are legal; the new word replaces the drained one.
- in_off, in_len, in_data and in_last are only sampled on accept.

Decomposition:
- Package vec_pack_pkg:
  - Width constants/functions: OFF_W = max(1, clog2(IN_W)), LEN_W, BITS_W.
  - Helper function left_align(stg, cnt).
- Sub-module vector_field_extract, combinational:
  - Inputs: in_data, in_off, in_len.
  - Outputs: f and an overrange flag (in_off+in_len > IN_W).
- All sequential state (stg, cnt, flush_pending, output register, err) lives in the top module.

Test Plan (IN_W=8, OUT_W=8, out_ready=1 unless noted):
1. Nibble concat: {data 0x0E, off0, len4}, then {data 0x7F, off0, len4} -> one cycle after beat 2: out_data=0xEF, out_bits=8, cnt=0.
2. Repeated slice: four beats {data 0xF5, off2, len2} -> single word 0x55 after beat 4; no output after beats 1-3.
3. Straddle + flush:
   - {0x3F, off0, len6} then {0x00, off0, len6} -> out_data 0xFC, bits 8.
   - Then {len0, last} -> out_data 0x00, out_bits 4.
4. Overflow with last: {0x3F, len6} then {0x0A, len4, last} -> 0xFE/bits 8, then next cycle 0x80/bits 2; in_ready=0 during the flush cycle.
5. Backpressure: out_ready=0 while out_valid -> in_ready=0, out_data stable for 5 cycles; raise out_ready -> drains, and a new accept happens the same cycle.
6. Overrange and reset:
   - {0xFF, off6, len4} -> field 0b0011 staged, err=1.
   - Assert rst with cnt=3 -> err=0, out_valid=0.
   - Next packed word contains no stale bits.
